// File: rtl/uart_rx_frame_checker_if.sv
// UART receive framer bus: line/tick/parity controls in, frame results out.
// master = line side (drives rx, baud_tick, parity cfg); slave = framer.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  baud_tick;
  logic                  rx;
  logic                  parity_en;
  logic                  parity_odd;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  busy;

  modport master (
    output baud_tick, rx, parity_en, parity_odd,
    input  data, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  baud_tick, rx, parity_en, parity_odd,
    output data, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX framer: sync rx, qualify start, deserialise LSB-first, check parity/stop.
// Ports: clk, rst (sync, active high), bus (slave: tick/rx/parity cfg in, frame out).
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input logic                     clk,
  input logic                     rst,
  uart_rx_frame_checker_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TMAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] THALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_BREAK  = 3'd6;

  logic                  meta_q, rxs_q;
  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  pen_q, pen_d;
  logic                  podd_q, podd_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  fe_q, fe_d;
  logic                  tick, wrap;

  assign tick = bus.baud_tick;
  assign wrap = tick && (tick_q == TMAX);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = pe_q;
    fe_d    = fe_q;
    // bit-period counter for the sampling states
    if (tick) tick_d = wrap ? '0 : tick_q + TW'(1);
    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (tick && !rxs_q) begin
          state_d = S_START;
          pen_d   = bus.parity_en;
          podd_d  = bus.parity_odd;
        end
      end
      S_START: begin
        if (tick && tick_q == THALF) begin
          tick_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (wrap) begin
          shift_d = {rxs_q, shift_q[DATA_WIDTH-1:1]};
          par_d   = par_q ^ rxs_q;
          if (bit_q == BLAST) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          perr_d  = rxs_q != (par_q ^ podd_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (!rxs_q) ferr_d = 1'b1;
          if (bit_q == SLAST) begin
            // results publish together with the valid pulse
            state_d = S_DONE;
            data_d  = shift_q;
            pe_d    = perr_q;
            fe_d    = ferr_q | ~rxs_q;
            dv_d    = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = (ferr_q && !rxs_q) ? S_BREAK : S_IDLE;
      end
      S_BREAK: begin
        if (tick && rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      meta_q  <= bus.rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker: 8-bit/1-stop and 5-bit/2-stop instances.
// Vector table for single frames plus hand sequences for reset, glitch, break, back-to-back.
module tb_uart_rx_frame_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_checker_if #(.DATA_WIDTH(8)) b8 ();
  uart_rx_frame_checker_if #(.DATA_WIDTH(5)) b5 ();

  uart_rx_frame_checker #(
    .DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(1)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(b8)
  );

  uart_rx_frame_checker #(
    .DATA_WIDTH(5), .OVERSAMPLE(16), .STOP_BITS(2)
  ) dut5 (
    .clk(clk), .rst(rst), .bus(b5)
  );

  int nchk = 0;
  int nerr = 0;

  int cnt8 = 0;
  int cnt5 = 0;
  logic [7:0] log_d [0:63];
  logic       log_pe [0:63];
  logic       log_fe [0:63];
  logic [4:0] d5;
  logic       pe5, fe5;

  always @(negedge clk) begin
    if (b8.data_valid) begin
      log_d[cnt8 % 64]  <= b8.data;
      log_pe[cnt8 % 64] <= b8.parity_err;
      log_fe[cnt8 % 64] <= b8.frame_err;
      cnt8 <= cnt8 + 1;
    end
    if (b5.data_valid) begin
      d5   <= b5.data;
      pe5  <= b5.parity_err;
      fe5  <= b5.frame_err;
      cnt5 <= cnt5 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input int sel, input logic b);
    if (sel == 8) b8.rx = b;
    else b5.rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d,
                            input int nb, input bit pen, input bit pbit,
                            input bit s1, input bit s2, input int ns);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(sel, d[i]);
    if (pen) send_bit(sel, pbit);
    send_bit(sel, s1);
    if (ns == 2) send_bit(sel, s2);
  endtask

  task automatic idle(input int nbits);
    b8.rx = 1'b1;
    b5.rx = 1'b1;
    repeat (nbits * 16) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         podd;
    bit         pbit;
    bit         stop;
    logic [7:0] ed;
    bit         epe;
    bit         efe;
  } vec_t;

  vec_t v [7];
  int   base;

  initial begin
    v[0] = '{8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0};
    v[1] = '{8'h3C, 1, 0, 0, 1, 8'h3C, 0, 0};
    v[2] = '{8'h3C, 1, 0, 1, 1, 8'h3C, 1, 0};
    v[3] = '{8'h01, 1, 1, 0, 1, 8'h01, 0, 0};
    v[4] = '{8'h01, 1, 1, 1, 1, 8'h01, 1, 0};
    v[5] = '{8'hFF, 1, 0, 0, 1, 8'hFF, 0, 0};
    v[6] = '{8'h55, 0, 0, 0, 0, 8'h55, 0, 1};

    b8.baud_tick = 1'b1; b8.rx = 1'b1;
    b8.parity_en = 1'b0; b8.parity_odd = 1'b0;
    b5.baud_tick = 1'b1; b5.rx = 1'b1;
    b5.parity_en = 1'b0; b5.parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", b8.data, 0);
    chk("rst_valid", b8.data_valid, 0);
    chk("rst_perr", b8.parity_err, 0);
    chk("rst_ferr", b8.frame_err, 0);
    chk("rst_busy", b8.busy, 0);
    idle(1);

    for (int i = 0; i < 7; i++) begin
      b8.parity_en  = v[i].pen;
      b8.parity_odd = v[i].podd;
      base = cnt8;
      send_frame(8, {1'b0, v[i].d}, 8, v[i].pen, v[i].pbit,
                 v[i].stop, 1'b1, 1);
      idle(3);
      chk($sformatf("v%0d_count", i), cnt8 - base, 1);
      chk($sformatf("v%0d_data", i), log_d[base % 64], v[i].ed);
      chk($sformatf("v%0d_perr", i), log_pe[base % 64], v[i].epe);
      chk($sformatf("v%0d_ferr", i), log_fe[base % 64], v[i].efe);
      chk($sformatf("v%0d_busy", i), b8.busy, 0);
    end

    // mid-frame reset aborts the frame
    b8.parity_en = 1'b0;
    base = cnt8;
    send_bit(8, 1'b0);
    send_bit(8, 1'b1);
    send_bit(8, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_data", b8.data, 0);
    chk("mrst_valid", b8.data_valid, 0);
    chk("mrst_ferr", b8.frame_err, 0);
    chk("mrst_busy", b8.busy, 0);
    b8.rx = 1'b1;
    rst = 1'b0;
    idle(12);
    chk("mrst_nofrm", cnt8 - base, 0);
    send_frame(8, 9'h05A, 8, 0, 0, 1, 1, 1);
    idle(2);
    chk("mrst_next_cnt", cnt8 - base, 1);
    chk("mrst_next_data", log_d[base % 64], 8'h5A);
    chk("mrst_next_err", {log_pe[base % 64], log_fe[base % 64]}, 0);

    // 4-tick glitch is rejected as a false start
    base = cnt8;
    b8.rx = 1'b0;
    repeat (4) @(negedge clk);
    b8.rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", b8.busy, 1);
    idle(2);
    chk("glitch_nofrm", cnt8 - base, 0);
    chk("glitch_busy_lo", b8.busy, 0);

    // line held low: one errored frame, then wait for release
    base = cnt8;
    b8.rx = 1'b0;
    repeat (20 * 16) @(negedge clk);
    chk("brk_count", cnt8 - base, 1);
    chk("brk_data", log_d[base % 64], 0);
    chk("brk_ferr", log_fe[base % 64], 1);
    chk("brk_busy", b8.busy, 1);
    idle(2);
    chk("brk_count2", cnt8 - base, 1);
    chk("brk_busy_lo", b8.busy, 0);
    send_frame(8, 9'h07E, 8, 0, 0, 1, 1, 1);
    idle(2);
    chk("brk_next_cnt", cnt8 - base, 2);
    chk("brk_next_data", log_d[(base + 1) % 64], 8'h7E);
    chk("brk_next_err",
        {log_pe[(base + 1) % 64], log_fe[(base + 1) % 64]}, 0);

    // three frames with no idle gap
    base = cnt8;
    send_frame(8, 9'h011, 8, 0, 0, 1, 1, 1);
    send_frame(8, 9'h022, 8, 0, 0, 1, 1, 1);
    send_frame(8, 9'h033, 8, 0, 0, 1, 1, 1);
    idle(2);
    chk("b2b_count", cnt8 - base, 3);
    chk("b2b_d0", log_d[base % 64], 8'h11);
    chk("b2b_d1", log_d[(base + 1) % 64], 8'h22);
    chk("b2b_d2", log_d[(base + 2) % 64], 8'h33);
    chk("b2b_err",
        {log_pe[base % 64], log_fe[base % 64],
         log_pe[(base + 1) % 64], log_fe[(base + 1) % 64],
         log_pe[(base + 2) % 64], log_fe[(base + 2) % 64]}, 0);

    // 5-bit, 2 stop bits: second stop low
    base = cnt5;
    send_frame(5, 9'h01F, 5, 0, 0, 1, 0, 2);
    idle(3);
    chk("w5_count", cnt5 - base, 1);
    chk("w5_data", d5, 5'h1F);
    chk("w5_ferr", fe5, 1);
    chk("w5_perr", pe5, 0);
    send_frame(5, 9'h00A, 5, 0, 0, 1, 1, 2);
    idle(2);
    chk("w5b_count", cnt5 - base, 2);
    chk("w5b_data", d5, 5'h0A);
    chk("w5b_ferr", fe5, 0);
    chk("w8_quiet", b8.busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
